// File: rtl/gnss_code_epoch_gen.sv
// gnss_code_epoch_gen: per-channel C/A code-phase NCO driving one epoch bit,
// with millisecond counting, wrap-aligned rate updates and snapshot capture.
module gnss_code_epoch_gen #(
  parameter int NCO_W      = 32,
  parameter int CODE_LEN   = 1023,
  parameter int EPOCH_HIGH = 512,
  parameter int MS_PER_BIT = 20
) (
  input  logic             clk_i,
  input  logic             nrst_i,
  input  logic             enable_i,
  input  logic [NCO_W-1:0] code_rate_in_i,
  input  logic             code_rate_ld_i,
  input  logic             phase_ld_i,
  input  logic [9:0]       chip_init_i,
  input  logic             snapshot_i,
  output logic [9:0]       chip_index_o,
  output logic             chip_tick_o,
  output logic             epoch_o,
  output logic [4:0]       ms_count_o,
  output logic [9:0]       snap_chip_o,
  output logic [NCO_W-1:0] snap_phase_o,
  output logic [4:0]       snap_ms_o,
  output logic             snap_valid_o
);
  logic [NCO_W-1:0] phase_q, phase_d, rate_q, rate_d, pend_rate_q, pend_rate_d, snap_phase_q;
  logic [9:0]       chip_q, chip_d, snap_chip_q;
  logic [4:0]       ms_q, ms_d, snap_ms_q;
  logic             pend_q, pend_d, tick_q, tick_d, epoch_q, epoch_d, snap_valid_q;
  logic [NCO_W:0]   sum;
  logic             adv, wrap, swap;
  // A stopped NCO (zero rate) never wraps, so a pending rate is adopted straight away.
  always_comb begin
    sum         = {1'b0, phase_q} + {1'b0, rate_q};
    adv         = enable_i && sum[NCO_W];
    wrap        = adv && !phase_ld_i && chip_q == 10'(CODE_LEN - 1);
    swap        = (wrap && (code_rate_ld_i || pend_q)) || (rate_q == '0 && pend_q);
    phase_d     = phase_ld_i ? '0 : enable_i ? sum[NCO_W-1:0] : phase_q;
    chip_d      = phase_ld_i ? (chip_init_i < 10'(CODE_LEN) ? chip_init_i : '0) :
                  !adv ? chip_q : wrap ? '0 : chip_q + 10'd1;
    ms_d        = phase_ld_i ? '0 : !wrap ? ms_q :
                  ms_q == 5'(MS_PER_BIT - 1) ? '0 : ms_q + 5'd1;
    tick_d      = adv && !phase_ld_i;
    epoch_d     = enable_i && chip_d < 10'(EPOCH_HIGH);
    rate_d      = !swap ? rate_q : (wrap && code_rate_ld_i) ? code_rate_in_i : pend_rate_q;
    pend_rate_d = code_rate_ld_i ? code_rate_in_i : pend_rate_q;
    pend_d      = code_rate_ld_i ? !wrap : swap ? 1'b0 : pend_q;
  end
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      phase_q      <= '0;
      rate_q       <= '0;
      pend_rate_q  <= '0;
      pend_q       <= 1'b0;
      chip_q       <= '0;
      ms_q         <= '0;
      tick_q       <= 1'b0;
      epoch_q      <= 1'b0;
      snap_chip_q  <= '0;
      snap_phase_q <= '0;
      snap_ms_q    <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      rate_q       <= rate_d;
      pend_rate_q  <= pend_rate_d;
      pend_q       <= pend_d;
      chip_q       <= chip_d;
      ms_q         <= ms_d;
      tick_q       <= tick_d;
      epoch_q      <= epoch_d;
      snap_valid_q <= snapshot_i;
      if (snapshot_i) begin
        snap_chip_q  <= chip_q;
        snap_phase_q <= phase_q;
        snap_ms_q    <= ms_q;
      end
    end
  end
  assign chip_index_o = chip_q;
  assign chip_tick_o  = tick_q;
  assign epoch_o      = epoch_q;
  assign ms_count_o   = ms_q;
  assign snap_chip_o  = snap_chip_q;
  assign snap_phase_o = snap_phase_q;
  assign snap_ms_o    = snap_ms_q;
  assign snap_valid_o = snap_valid_q;
endmodule

// File: doc/gnss_code_epoch_gen.md
Name: gnss_code_epoch_gen

Overview:
- Per-channel C/A code-phase NCO and epoch generator; one instance per tracking channel.
- Drives one bit of the satellite block's 32-bit epoch bus. The satellite block latches a CSR bit on each falling edge of that bit.
- Consumes the satellite block's broadcast snapshot pulse and freezes this channel's code phase, chip index and millisecond count for later readout.

Parameters:
- NCO_W, 32: code NCO phase accumulator width.
- CODE_LEN, 1023: chips per code period.
- EPOCH_HIGH, 512: epoch is high while chip_index < EPOCH_HIGH.
- MS_PER_BIT, 20: code periods per navigation bit; sets the ms_count modulus.

Ports:
- clk  in  1  sample clock, single domain.
- nrst  in  1  synchronous active-low reset.
- enable  in  1  advances the NCO when high.
- code_rate_in  in  NCO_W  requested code NCO increment per clk.
- code_rate_ld  in  1  one-cycle strobe; captures code_rate_in as pending rate.
- phase_ld  in  1  one-cycle strobe; immediate code phase load.
- chip_init  in  10  chip index loaded by phase_ld.
- snapshot  in  1  one-cycle snapshot pulse from the satellite block.
- chip_index  out  10  current chip, 0..CODE_LEN-1.
- chip_tick  out  1  one-cycle pulse when chip_index advances.
- epoch  out  1  level; high for the first EPOCH_HIGH chips of each code period.
- ms_count  out  5  code periods elapsed in the current bit, 0..MS_PER_BIT-1.
- snap_chip  out  10  chip_index captured at snapshot.
- snap_phase  out  NCO_W  NCO phase captured at snapshot.
- snap_ms  out  5  ms_count captured at snapshot.
- snap_valid  out  1  one-cycle pulse, one clk after capture.

Behaviour:
- Reset (nrst low at posedge clk): phase, chip_index, ms_count, active rate, pending rate, pending flag, all snap_* outputs, chip_tick, snap_valid all 0. epoch reset 0. Reset mid-operation discards any pending rate.
- Accumulation, each clk with enable=1: {carry, phase} <= phase + rate_active, with NCO_W-bit wrap. carry=1 advances the chip.
- enable=0: phase, chip_index and ms_count hold. chip_tick=0. epoch=0. Epoch is forced low whenever disabled, so disabling mid-high yields one falling edge.
- Chip advance: chip_index <= chip_index+1, or 0 when chip_index = CODE_LEN-1 (the wrap). chip_tick=1 in the cycle following the advance edge.
- Wrap: ms_count <= ms_count+1, or 0 when ms_count = MS_PER_BIT-1.
- Epoch: registered. epoch <= enable && (next chip_index < EPOCH_HIGH). This gives exactly one falling edge per code period when enabled.
- Rate update: code_rate_ld sets pending rate and pending flag; a later ld overwrites the earlier one.
  - At a wrap edge with pending=1: rate_active <= pending rate and pending clears.
  - The add at the wrap edge itself uses the old rate.
  - code_rate_ld on the same cycle as a wrap: the new value is applied at that wrap; it is not deferred.
- Phase load (phase_ld=1): phase <= 0, chip_index <= chip_init, ms_count <= 0. chip_tick suppressed that cycle.
  - Takes priority over accumulation and wrap. Does not affect the pending rate.
  - chip_init >= CODE_LEN loads 0.
- Snapshot (snapshot=1): snap_chip/phase/ms capture the pre-edge registered values, i.e. values before any same-cycle advance or phase_ld. snap_valid=1 on the next cycle.
  - Back-to-back snapshots each capture and each pulse snap_valid.
  - Snapshot while enable=0 still captures.
- Latency: code_rate_ld has no effect until the next wrap. phase_ld takes effect on the next edge. Snapshot data is valid at the same edge snap_valid rises.

Test Plan:
- Rate 32'h8000_0000 loaded, phase_ld chip_init=0, enable=1: chip_tick every 2 clk. Wrap after 2046 clk. epoch high 1024 clk, low 1022 clk.
- Run 20 wraps at rate 2^31: ms_count 0→19 then 0. The 21st epoch falling edge occurs with ms_count=0.
- code_rate_ld=32'h4000_0000 mid-period at chip 300: chips stay 2 clk until the wrap. Afterwards chip_tick every 4 clk. Repeat with ld on the exact wrap cycle: new rate applies at that wrap.
- snapshot at chip 700, phase 32'h8000_0000, together with phase_ld chip_init=5: snap_chip=700, snap_phase=32'h8000_0000, snap_valid pulses next cycle. chip_index=5.
- enable dropped at chip 100: epoch falls next cycle, counters hold. Re-enable: resumes from chip 100, epoch re-rises. chip_init=1023: chip_index=0.
- nrst asserted mid-period with pending rate: all outputs 0. After release with enable=1 and rate still 0: no chip_tick, epoch rises (chip 0 < 512).
